// File: rtl/rv_hazard_ctrl_if.sv
// Encodings shared by the hazard controller and its pipeline-status bundle.
// The pipeline side uses the master modport and the controller uses the slave modport.
package rv_hazard_pkg;

  typedef enum logic [1:0] {
    RESULT_SRC_ALU    = 2'd0,
    RESULT_SRC_MEMORY = 2'd1,
    RESULT_SRC_PC4    = 2'd2,
    RESULT_SRC_CSR    = 2'd3
  } result_src_t;

  typedef enum logic [1:0] {
    STAGED_BP_DIRECT   = 2'd0,
    STAGED_BP_MEMORY   = 2'd1,
    STAGED_BP_WRITE_BK = 2'd2
  } bp_sel_t;

endpackage

interface rv_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   import rv_hazard_pkg::*;

   logic                  i_fetch_bus_ack;
   logic [REG_ADDR_W-1:0] i_decode_rs1;
   logic [REG_ADDR_W-1:0] i_decode_rs2;
   logic                  i_decode_rs1_used;
   logic                  i_decode_rs2_used;
   logic                  i_decode_inv_instr;
   logic [REG_ADDR_W-1:0] i_exec_rs1;
   logic [REG_ADDR_W-1:0] i_exec_rs2;
   logic [REG_ADDR_W-1:0] i_exec_rd;
   logic                  i_exec_reg_write;
   result_src_t           i_exec_res_src;
   logic                  i_exec_pc_sel;
   logic                  i_exec_busy;
   logic [REG_ADDR_W-1:0] i_memory_rd;
   logic                  i_memory_reg_write;
   logic [REG_ADDR_W-1:0] i_write_back_rd;
   logic                  i_write_back_write;
   logic                  i_trap_clear;

   bp_sel_t               o_exec_bp_rs1;
   bp_sel_t               o_exec_bp_rs2;
   logic                  o_fetch_stall;
   logic                  o_decode_stall;
   logic                  o_exec_stall;
   logic                  o_decode_flush;
   logic                  o_exec_flush;
   logic                  o_memory_flush;
   logic                  o_halted;
   logic [CNT_W-1:0]      o_stall_cycles;
   logic [CNT_W-1:0]      o_redirects;

   modport master (
      output i_fetch_bus_ack, i_decode_rs1, i_decode_rs2, i_decode_rs1_used,
             i_decode_rs2_used, i_decode_inv_instr, i_exec_rs1, i_exec_rs2,
             i_exec_rd, i_exec_reg_write, i_exec_res_src, i_exec_pc_sel,
             i_exec_busy, i_memory_rd, i_memory_reg_write, i_write_back_rd,
             i_write_back_write, i_trap_clear,
      input  o_exec_bp_rs1, o_exec_bp_rs2, o_fetch_stall, o_decode_stall,
             o_exec_stall, o_decode_flush, o_exec_flush, o_memory_flush,
             o_halted, o_stall_cycles, o_redirects
   );

   modport slave (
      input  i_fetch_bus_ack, i_decode_rs1, i_decode_rs2, i_decode_rs1_used,
             i_decode_rs2_used, i_decode_inv_instr, i_exec_rs1, i_exec_rs2,
             i_exec_rd, i_exec_reg_write, i_exec_res_src, i_exec_pc_sel,
             i_exec_busy, i_memory_rd, i_memory_reg_write, i_write_back_rd,
             i_write_back_write, i_trap_clear,
      output o_exec_bp_rs1, o_exec_bp_rs2, o_fetch_stall, o_decode_stall,
             o_exec_stall, o_decode_flush, o_exec_flush, o_memory_flush,
             o_halted, o_stall_cycles, o_redirects
   );

endinterface

// File: rtl/rv_hazard_ctrl.sv
// Pipeline hazard/forwarding controller: FLUSH/RUN/HALT sequencing, stall and flush
// generation, operand bypass selection and saturating performance counters.
module rv_hazard_ctrl
   import rv_hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int FLUSH_DEPTH = 2,   // legal range 1..15
   parameter int CNT_W       = 32
) (
   input  logic           i_clk,
   input  logic           i_reset,
   rv_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

   state_t           state_q;
   logic [3:0]       flush_cnt_q;
   logic             halted_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] redirect_cnt_q;

   logic load_use;
   logic bus_wait;
   logic redirect;
   logic run_stall;
   logic halt_req;

   logic fetch_stall;
   logic decode_stall;
   logic exec_stall;
   logic decode_flush;
   logic exec_flush;
   logic memory_flush;

   // The newest producer (memory stage) wins over write-back; x0 is never forwarded.
   function automatic bp_sel_t bypass_sel(
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] mem_rd,
      input logic                  mem_we,
      input logic [REG_ADDR_W-1:0] wb_rd,
      input logic                  wb_we
   );
      if (mem_we && (src != '0) && (src == mem_rd)) begin
         return STAGED_BP_MEMORY;
      end
      if (wb_we && (src != '0) && (src == wb_rd)) begin
         return STAGED_BP_WRITE_BK;
      end
      return STAGED_BP_DIRECT;
   endfunction

   assign load_use = (bus.i_exec_res_src == RESULT_SRC_MEMORY) && bus.i_exec_reg_write &&
                     (bus.i_exec_rd != '0) &&
                     ((bus.i_decode_rs1_used && (bus.i_decode_rs1 == bus.i_exec_rd)) ||
                      (bus.i_decode_rs2_used && (bus.i_decode_rs2 == bus.i_exec_rd)));
   assign bus_wait  = !bus.i_fetch_bus_ack;
   assign redirect  = bus.i_exec_pc_sel && !bus.i_exec_busy;
   assign run_stall = bus.i_exec_busy || load_use || bus_wait;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      fetch_stall  = 1'b0;
      decode_stall = 1'b0;
      exec_stall   = 1'b0;
      decode_flush = 1'b1;
      exec_flush   = 1'b1;
      memory_flush = 1'b1;
      case (state_q)
         ST_RUN: begin
            fetch_stall  = run_stall;
            decode_stall = run_stall;
            exec_stall   = bus.i_exec_busy;
            memory_flush = bus.i_exec_busy;
            // A stalled multi-cycle instruction must survive, so busy masks the exec flush.
            exec_flush   = !bus.i_exec_busy && (redirect || load_use || bus_wait);
            decode_flush = redirect;
         end
         ST_HALT: begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            exec_stall   = 1'b1;
         end
         default: ;
      endcase
   end

   assign halt_req = (state_q == ST_RUN) && bus.i_decode_inv_instr &&
                     !decode_flush && !decode_stall;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_FLUSH;
         flush_cnt_q <= FLUSH_LOAD;
         halted_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_FLUSH: begin
               if (flush_cnt_q == '0) begin
                  state_q <= ST_RUN;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end
            end
            ST_HALT: begin
               if (bus.i_trap_clear) begin
                  state_q     <= ST_FLUSH;
                  flush_cnt_q <= FLUSH_LOAD;
                  halted_q    <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_FLUSH;
               flush_cnt_q <= FLUSH_LOAD;
               halted_q    <= 1'b0;
            end
         endcase
      end
   end

   // Counters only observe RUN cycles and stick at all-ones instead of wrapping.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         if (fetch_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (redirect && (redirect_cnt_q != '1)) begin
            redirect_cnt_q <= redirect_cnt_q + 1'b1;
         end
      end
   end

   assign bus.o_fetch_stall  = fetch_stall;
   assign bus.o_decode_stall = decode_stall;
   assign bus.o_exec_stall   = exec_stall;
   assign bus.o_decode_flush = decode_flush;
   assign bus.o_exec_flush   = exec_flush;
   assign bus.o_memory_flush = memory_flush;
   assign bus.o_halted       = halted_q;
   assign bus.o_stall_cycles = stall_cnt_q;
   assign bus.o_redirects    = redirect_cnt_q;

   assign bus.o_exec_bp_rs1 = bypass_sel(bus.i_exec_rs1, bus.i_memory_rd, bus.i_memory_reg_write,
                                         bus.i_write_back_rd, bus.i_write_back_write);
   assign bus.o_exec_bp_rs2 = bypass_sel(bus.i_exec_rs2, bus.i_memory_rd, bus.i_memory_reg_write,
                                         bus.i_write_back_rd, bus.i_write_back_write);

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a mode/count reference model.
module tb_rv_hazard_ctrl;
   import rv_hazard_pkg::*;

   localparam int REG_ADDR_W  = 5;
   localparam int FLUSH_DEPTH = 2;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   always #5 i_clk = ~i_clk;

   rv_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hif ();

   rv_hazard_ctrl #(
      .REG_ADDR_W (REG_ADDR_W),
      .FLUSH_DEPTH(FLUSH_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .bus    (hif)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: remaining flush cycles, halt flag and saturating event counts.
   int m_flush_left;
   bit m_halted;
   int m_stalls;
   int m_redirs;

   // Expectations for the current cycle, reused when the model advances at the edge.
   bit e_fetch_stall, e_decode_stall, e_exec_stall;
   bit e_decode_flush, e_exec_flush, e_memory_flush;
   bit e_redirect;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_bp(input logic [REG_ADDR_W-1:0] src);
      if (src == 0) return int'(STAGED_BP_DIRECT);
      if (hif.i_memory_reg_write && src == hif.i_memory_rd) return int'(STAGED_BP_MEMORY);
      if (hif.i_write_back_write && src == hif.i_write_back_rd) return int'(STAGED_BP_WRITE_BK);
      return int'(STAGED_BP_DIRECT);
   endfunction

   task automatic model_reset();
      m_flush_left = FLUSH_DEPTH;
      m_halted     = 1'b0;
      m_stalls     = 0;
      m_redirs     = 0;
   endtask

   task automatic check_outputs(input string ph);
      bit busy, load_hit, waiting;
      busy    = hif.i_exec_busy;
      waiting = !hif.i_fetch_bus_ack;
      load_hit = 1'b0;
      if (hif.i_exec_res_src == RESULT_SRC_MEMORY && hif.i_exec_reg_write && hif.i_exec_rd != 0) begin
         if (hif.i_decode_rs1_used && hif.i_decode_rs1 == hif.i_exec_rd) load_hit = 1'b1;
         if (hif.i_decode_rs2_used && hif.i_decode_rs2 == hif.i_exec_rd) load_hit = 1'b1;
      end
      e_redirect = 1'b0;
      if (m_halted) begin
         {e_fetch_stall, e_decode_stall, e_exec_stall} = 3'b111;
         {e_decode_flush, e_exec_flush, e_memory_flush} = 3'b111;
      end else if (m_flush_left > 0) begin
         {e_fetch_stall, e_decode_stall, e_exec_stall} = 3'b000;
         {e_decode_flush, e_exec_flush, e_memory_flush} = 3'b111;
      end else begin
         e_redirect     = hif.i_exec_pc_sel && !busy;
         e_fetch_stall  = busy || load_hit || waiting;
         e_decode_stall = e_fetch_stall;
         e_exec_stall   = busy;
         e_memory_flush = busy;
         e_exec_flush   = busy ? 1'b0 : (e_redirect || load_hit || waiting);
         e_decode_flush = e_redirect;
      end
      check({ph, ".fetch_stall"},  32'(hif.o_fetch_stall),  32'(e_fetch_stall));
      check({ph, ".decode_stall"}, 32'(hif.o_decode_stall), 32'(e_decode_stall));
      check({ph, ".exec_stall"},   32'(hif.o_exec_stall),   32'(e_exec_stall));
      check({ph, ".decode_flush"}, 32'(hif.o_decode_flush), 32'(e_decode_flush));
      check({ph, ".exec_flush"},   32'(hif.o_exec_flush),   32'(e_exec_flush));
      check({ph, ".memory_flush"}, 32'(hif.o_memory_flush), 32'(e_memory_flush));
      check({ph, ".halted"},       32'(hif.o_halted),       32'(m_halted));
      check({ph, ".bp_rs1"},       32'(hif.o_exec_bp_rs1),  32'(exp_bp(hif.i_exec_rs1)));
      check({ph, ".bp_rs2"},       32'(hif.o_exec_bp_rs2),  32'(exp_bp(hif.i_exec_rs2)));
      check({ph, ".stall_cycles"}, 32'(hif.o_stall_cycles), 32'(m_stalls));
      check({ph, ".redirects"},    32'(hif.o_redirects),    32'(m_redirs));
   endtask

   task automatic advance();
      if (m_halted) begin
         if (hif.i_trap_clear) begin
            m_halted     = 1'b0;
            m_flush_left = FLUSH_DEPTH;
         end
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else begin
         if (e_fetch_stall && m_stalls < CNT_MAX) m_stalls++;
         if (e_redirect && m_redirs < CNT_MAX) m_redirs++;
         if (hif.i_decode_inv_instr && !e_decode_flush && !e_decode_stall) m_halted = 1'b1;
      end
   endtask

   // One clock: compare mid-cycle, then move the model across the rising edge.
   task automatic step(input string ph);
      @(negedge i_clk);
      check_outputs(ph);
      @(posedge i_clk);
      advance();
      #1;
   endtask

   task automatic idle();
      hif.i_fetch_bus_ack    = 1'b1;
      hif.i_decode_rs1       = '0;
      hif.i_decode_rs2       = '0;
      hif.i_decode_rs1_used  = 1'b0;
      hif.i_decode_rs2_used  = 1'b0;
      hif.i_decode_inv_instr = 1'b0;
      hif.i_exec_rs1         = '0;
      hif.i_exec_rs2         = '0;
      hif.i_exec_rd          = '0;
      hif.i_exec_reg_write   = 1'b0;
      hif.i_exec_res_src     = RESULT_SRC_ALU;
      hif.i_exec_pc_sel      = 1'b0;
      hif.i_exec_busy        = 1'b0;
      hif.i_memory_rd        = '0;
      hif.i_memory_reg_write = 1'b0;
      hif.i_write_back_rd    = '0;
      hif.i_write_back_write = 1'b0;
      hif.i_trap_clear       = 1'b0;
   endtask

   // Asynchronous reset: outputs must react before any clock edge.
   task automatic do_reset(input string ph);
      i_reset = 1'b1;
      model_reset();
      #1;
      check_outputs(ph);
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
   endtask

   task automatic randomize_inputs();
      hif.i_fetch_bus_ack    = ($urandom_range(0, 9) != 0);
      hif.i_decode_rs1       = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_decode_rs2       = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_decode_rs1_used  = ($urandom_range(0, 1) == 1);
      hif.i_decode_rs2_used  = ($urandom_range(0, 1) == 1);
      hif.i_decode_inv_instr = ($urandom_range(0, 24) == 0);
      hif.i_exec_rs1         = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_exec_rs2         = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_exec_rd          = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_exec_reg_write   = ($urandom_range(0, 1) == 1);
      hif.i_exec_res_src     = result_src_t'($urandom_range(0, 3));
      hif.i_exec_pc_sel      = ($urandom_range(0, 5) == 0);
      hif.i_exec_busy        = ($urandom_range(0, 4) == 0);
      hif.i_memory_rd        = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_memory_reg_write = ($urandom_range(0, 1) == 1);
      hif.i_write_back_rd    = REG_ADDR_W'($urandom_range(0, 7));
      hif.i_write_back_write = ($urandom_range(0, 1) == 1);
      hif.i_trap_clear       = ($urandom_range(0, 4) == 0);
   endtask

   initial begin
      idle();
      do_reset("reset");
      step("flush0");
      step("flush1");
      step("run_idle");

      // Load-use on rs1, then the same load with the hazard qualifiers removed.
      hif.i_exec_res_src = RESULT_SRC_MEMORY;
      hif.i_exec_reg_write = 1'b1;
      hif.i_exec_rd = 5'd5;
      hif.i_decode_rs1 = 5'd5;
      hif.i_decode_rs1_used = 1'b1;
      step("load_use");
      hif.i_decode_rs1_used = 1'b0;
      step("load_unused");
      hif.i_decode_rs1_used = 1'b1;
      hif.i_exec_rd = 5'd0;
      step("load_x0");
      idle();
      step("after_load");

      // Redirect held off by a busy multi-cycle unit, accepted once it drops.
      hif.i_exec_pc_sel = 1'b1;
      hif.i_exec_busy = 1'b1;
      for (int i = 0; i < 4; i++) step("busy_redirect");
      hif.i_exec_busy = 1'b0;
      step("redirect");
      idle();
      step("after_redirect");

      // Forwarding priority.
      hif.i_exec_rs1 = 5'd7;
      hif.i_exec_rs2 = 5'd7;
      hif.i_memory_rd = 5'd7;
      hif.i_memory_reg_write = 1'b1;
      hif.i_write_back_rd = 5'd7;
      hif.i_write_back_write = 1'b1;
      step("fwd_mem");
      hif.i_memory_reg_write = 1'b0;
      step("fwd_wb");
      hif.i_exec_rs1 = 5'd0;
      step("fwd_x0");
      idle();

      // Killed illegal instruction, stray trap clear, then a real halt and resume.
      hif.i_decode_inv_instr = 1'b1;
      hif.i_exec_pc_sel = 1'b1;
      step("inv_killed");
      idle();
      hif.i_trap_clear = 1'b1;
      step("stray_clear");
      idle();
      step("no_halt");
      hif.i_decode_inv_instr = 1'b1;
      step("inv_run");
      idle();
      step("halted0");
      step("halted1");
      hif.i_trap_clear = 1'b1;
      step("trap_clear");
      idle();
      for (int i = 0; i < FLUSH_DEPTH + 2; i++) step("resume");

      // Stall counter saturation.
      hif.i_fetch_bus_ack = 1'b0;
      for (int i = 0; i < 20; i++) step("bus_wait");
      idle();
      @(negedge i_clk);
      check("stall_saturated", 32'(hif.o_stall_cycles), 32'(CNT_MAX));
      @(posedge i_clk);
      advance();
      #1;

      do_reset("reset_mid");
      for (int i = 0; i < 3000; i++) begin
         randomize_inputs();
         if ($urandom_range(0, 499) == 0) begin
            do_reset("reset_rand");
         end else begin
            step("random");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_hazard_ctrl.md
# rv_hazard_ctrl

Parametrised pipeline hazard and forwarding controller for the 5-stage RISC-V core, the next generation of the core's pipeline control. It generates per-stage stall/flush controls and operand-bypass selects from fetch, decode, execute, memory and write-back status. It adds the following on top of plain load-use/branch handling:
- multi-cycle execute support (busy stall);
- a configurable post-reset flush sequence;
- a halt/resume state machine for invalid instructions;
- saturating stall and redirect performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- FLUSH_DEPTH, 2, cycles of forced flush after reset or trap clear (1..15)
- CNT_W, 32, performance counter width

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_fetch_bus_ack  in  1  instruction bus returned data this cycle
- i_decode_rs1, i_decode_rs2  in  REG_ADDR_W  decode source indices
- i_decode_rs1_used, i_decode_rs2_used  in  1  decode instruction reads that source
- i_decode_inv_instr  in  1  decode holds an illegal instruction
- i_exec_rs1, i_exec_rs2, i_exec_rd  in  REG_ADDR_W  execute indices
- i_exec_reg_write  in  1  execute instruction writes rd
- i_exec_res_src  in  2  execute result source (RESULT_SRC_* encoding)
- i_exec_pc_sel  in  1  execute redirects PC (taken branch/jump)
- i_exec_busy  in  1  multi-cycle unit in execute not finished
- i_memory_rd  in  REG_ADDR_W; i_memory_reg_write  in  1
- i_write_back_rd  in  REG_ADDR_W; i_write_back_write  in  1
- i_trap_clear  in  1  single-cycle pulse, leave HALT
- o_exec_bp_rs1, o_exec_bp_rs2  out  2  bypass select (STAGED_BP_* encoding)
- o_fetch_stall, o_decode_stall, o_exec_stall  out  1
- o_decode_flush, o_exec_flush, o_memory_flush  out  1
- o_halted  out  1  controller in HALT
- o_stall_cycles  out  CNT_W  RUN cycles with o_fetch_stall=1
- o_redirects  out  CNT_W  accepted PC redirects

## Operation
- States: FLUSH, RUN, HALT. Reset enters FLUSH with flush counter = FLUSH_DEPTH-1.
- FLUSH:
  - outputs: o_decode_flush=o_exec_flush=o_memory_flush=1; all stalls 0.
  - the counter decrements each cycle; when counter=0, go to RUN next cycle.
- RUN hazard terms:
  - load_use = (res_src==RESULT_SRC_MEMORY) & i_exec_reg_write & (i_exec_rd!=0) & ((rs1_used & i_decode_rs1==i_exec_rd) | (rs2_used & i_decode_rs2==i_exec_rd)).
  - bus_wait = !i_fetch_bus_ack.
  - redirect = i_exec_pc_sel & !i_exec_busy. pc_sel is ignored while busy.
- RUN outputs:
  - o_exec_stall = o_memory_flush = i_exec_busy.
  - o_fetch_stall = o_decode_stall = i_exec_busy | load_use | bus_wait.
  - o_exec_flush = !i_exec_busy & (redirect | load_use | bus_wait). Busy has priority: a stalled exec instruction is never flushed.
  - o_decode_flush = redirect.
- RUN to HALT: i_decode_inv_instr & !o_decode_flush & !o_decode_stall. A killed or stalled illegal instruction does not halt.
- HALT:
  - outputs: fetch/decode/exec stalls=1, decode/exec/memory flushes=1, o_halted=1.
  - i_trap_clear moves to FLUSH, counter reloaded. i_trap_clear outside HALT is ignored.
- Forwarding, per source s:
  - MEMORY if i_memory_reg_write & s!=0 & s==i_memory_rd;
  - else WRITE_BK if i_write_back_write & s!=0 & s==i_write_back_rd;
  - else DIRECT.
  - Memory wins when both match. Forwarding is computed in all states.
- Counters:
  - reset to 0 and saturate at all-ones (no wrap);
  - o_stall_cycles increments on RUN cycles with o_fetch_stall=1;
  - o_redirects increments on each redirect.

## Timing
- All control outputs are combinational from inputs plus registered state; zero-cycle latency.
- State, flush counter and counters update on the rising i_clk edge.
- Counter outputs reflect events up to the previous cycle (1-cycle latency).
- Asserting i_reset mid-operation returns immediately to FLUSH. Counters clear to 0.
- During reset, outputs are: decode/exec/memory flush=1, stalls=0, o_halted=0, bypass=DIRECT for non-matching sources.
- HALT entry: illegal instruction seen at cycle N, o_halted=1 from cycle N+1.
- Resume: i_trap_clear at cycle M gives FLUSH for cycles M+1..M+FLUSH_DEPTH, then RUN.

## Test plan
- Reset with FLUSH_DEPTH=2, release at cycle 0 -> flushes high cycles 0-1, RUN at cycle 2, counters 0.
- Load x5 in exec, decode rs1=x5 used, ack=1 -> fetch/decode stall=1, exec_flush=1 for one cycle, o_stall_cycles increments by 1.
- Same load with decode rs1_used=0 or i_exec_rd=0 -> no stall.
- i_exec_busy=1 for 4 cycles with i_exec_pc_sel=1 -> exec_stall=1, memory_flush=1, exec_flush=0 and o_redirects unchanged for all 4 cycles. Busy drops -> redirect accepted, decode/exec flush=1, o_redirects+1.
- Forwarding with exec rs1=rs2=x7, memory rd=x7 and write-back rd=x7 -> both MEMORY. With memory_reg_write=0 -> both WRITE_BK. With rs1=x0 -> DIRECT.
- Illegal instruction in RUN -> o_halted next cycle, all stalls/flushes 1. An illegal instruction with decode_flush=1 -> no halt. i_trap_clear -> FLUSH_DEPTH flush cycles, then RUN. With CNT_W=4, 20 stall cycles -> o_stall_cycles=15.
